// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package inst_loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/inst_loader_word_assembler.sv
// Packs stream bytes big-endian into a 32-bit word; flags the byte that completes it.
module inst_loader_word_assembler
    import inst_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        shift_en,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last
);

    logic [1:0] byte_idx;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (shift_en) begin
            word     <= {word[23:0], byte_in};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    assign last = (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_loader.sv
// Loads a length-prefixed byte stream into instruction memory, holding the CPU in reset meanwhile.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              restart,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] DEPTH_EXT = 17'(1) << ADDR_W;

    state_t            state, state_next;
    logic [15:0]       count;
    logic [ADDR_W-1:0] word_idx;
    logic [15:0]       hdr_n;
    logic              accept;
    logic              last_word;
    logic              asm_last;
    logic [31:0]       asm_word;

    logic ld_hi, ld_lo, clr_all, idx_clr, idx_inc, asm_shift, asm_clear;

    assign in_ready  = reset && (state == HDR_HI || state == HDR_LO || state == DATA);
    assign accept    = in_valid && in_ready;
    assign hdr_n     = {count[15:8], in_data};
    assign last_word = (17'(word_idx) + 17'd1) == {1'b0, count};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= HDR_HI;
        else        state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        ld_hi      = 1'b0;
        ld_lo      = 1'b0;
        clr_all    = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        asm_shift  = 1'b0;
        asm_clear  = 1'b0;
        case (state)
            HDR_HI: if (accept) begin
                ld_hi      = 1'b1;
                state_next = HDR_LO;
            end
            HDR_LO: if (accept) begin
                ld_lo = 1'b1;
                if (hdr_n == 16'd0) begin
                    state_next = DONE;
                end else if ({1'b0, hdr_n} > DEPTH_EXT) begin
                    state_next = ERR;
                end else begin
                    idx_clr    = 1'b1;
                    asm_clear  = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: if (accept) begin
                asm_shift = 1'b1;
                if (asm_last) state_next = WRITE;
            end
            WRITE: begin
                if (last_word) begin
                    state_next = DONE;
                end else begin
                    idx_inc    = 1'b1;
                    asm_clear  = 1'b1;
                    state_next = DATA;
                end
            end
            DONE, ERR: if (restart) begin
                clr_all    = 1'b1;
                asm_clear  = 1'b1;
                state_next = HDR_HI;
            end
            default: state_next = HDR_HI;
        endcase
    end

    // Status strobes are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            word_idx  <= '0;
            mem_wr_en <= 1'b0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (clr_all)    count       <= '0;
            else if (ld_hi) count[15:8] <= in_data;
            else if (ld_lo) count[7:0]  <= in_data;

            if (clr_all || idx_clr) word_idx <= '0;
            else if (idx_inc)       word_idx <= word_idx + ADDR_W'(1);

            mem_wr_en <= (state_next == WRITE);
            done      <= (state_next == DONE);
            error     <= (state_next == ERR);
            cpu_reset <= (state_next != DONE);
        end
    end

    inst_loader_word_assembler u_asm (
        .clock    (clock),
        .reset    (reset),
        .shift_en (asm_shift),
        .clear    (asm_clear),
        .byte_in  (in_data),
        .word     (asm_word),
        .last     (asm_last)
    );

    // The word index and the assembler hold steady through WRITE, so they drive memory directly.
    assign mem_addr = word_idx;
    assign mem_data = asm_word;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: scoreboarded writes, table-driven programs, corner sequences.
module tb_inst_loader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       in_valid, restart, in_ready;
    logic [7:0] in_data;
    logic       mem_wr_en, cpu_reset, done, error;
    logic [9:0] mem_addr;
    logic [31:0] mem_data;

    logic       s_in_valid, s_restart, s_in_ready;
    logic [7:0] s_in_data;
    logic       s_mem_wr_en, s_cpu_reset, s_done, s_error;
    logic [1:0] s_mem_addr;
    logic [31:0] s_mem_data;

    inst_loader #(.ADDR_W(10)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .restart(restart), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_data(mem_data), .cpu_reset(cpu_reset),
        .done(done), .error(error)
    );

    inst_loader #(.ADDR_W(2)) dut_s (
        .clock(clock), .reset(reset), .in_valid(s_in_valid), .in_data(s_in_data),
        .in_ready(s_in_ready), .restart(s_restart), .mem_wr_en(s_mem_wr_en),
        .mem_addr(s_mem_addr), .mem_data(s_mem_data), .cpu_reset(s_cpu_reset),
        .done(s_done), .error(s_error)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [15:0]       n;
        logic [3:0][31:0]  w;
        bit                gaps;
        int                exp_writes;
    } vec_t;

    wr_t exp_q[$];
    wr_t s_exp_q[$];
    wr_t mon_e, s_mon_e;
    int  n_cmp = 0, n_err = 0;
    int  wr_count = 0, s_wr_count = 0;
    int  cyc = 0, last_wr_cyc = 0, wr_gap = 0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (mem_wr_en === 1'b1) begin
            wr_count++;
            wr_gap      = cyc - last_wr_cyc;
            last_wr_cyc = cyc;
            check("wr_in_ready_low", in_ready, 0);
            if (exp_q.size() == 0) begin
                check("wr_unexpected", mem_wr_en, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                check("wr_data", mem_data, mon_e.data);
            end
        end
        if (s_mem_wr_en === 1'b1) begin
            s_wr_count++;
            if (s_exp_q.size() == 0) begin
                check("s_wr_unexpected", s_mem_wr_en, 0);
            end else begin
                s_mon_e = s_exp_q.pop_front();
                check("s_wr_addr", 32'(s_mem_addr), 32'(s_mon_e.addr));
                check("s_wr_data", s_mem_data, s_mon_e.data);
            end
        end
    end

    task automatic set_in(input bit sel, input logic v, input logic [7:0] b);
        if (sel) begin s_in_valid = v; s_in_data = b; end
        else     begin in_valid   = v; in_data   = b; end
    endtask

    // Called and returns at posedge+1; a held byte stays offered until an edge with in_ready=1.
    task automatic send_byte(input bit sel, input logic [7:0] b, input bit gaps);
        bit r = 1'b0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                set_in(sel, 1'b0, 8'($urandom));
                @(posedge clock); #1;
            end
        end
        set_in(sel, 1'b1, b);
        for (int t = 0; t < 50 && !r; t++) begin
            @(negedge clock);
            r = sel ? s_in_ready : in_ready;
            @(posedge clock); #1;
        end
        set_in(sel, 1'b0, 8'h00);
        if (!r) check("accept_timeout", r, 1);
    endtask

    task automatic send_prog(input bit sel, input logic [15:0] n,
                             input logic [3:0][31:0] w, input bit gaps);
        wr_t e;
        send_byte(sel, n[15:8], gaps);
        send_byte(sel, n[7:0], gaps);
        for (int i = 0; i < int'(n); i++) begin
            for (int k = 3; k >= 0; k--) send_byte(sel, w[i][k*8 +: 8], gaps);
            e.addr = 16'(i);
            e.data = w[i];
            if (sel) s_exp_q.push_back(e);
            else     exp_q.push_back(e);
        end
    endtask

    task automatic pulse_restart(input bit sel);
        if (sel) s_restart = 1'b1; else restart = 1'b1;
        @(posedge clock); #1;
        s_restart = 1'b0;
        restart   = 1'b0;
        @(negedge clock);
        check("rst_cpu_reset", sel ? s_cpu_reset : cpu_reset, 1);
        check("rst_done",      sel ? s_done      : done,      0);
        check("rst_error",     sel ? s_error     : error,     0);
        check("rst_in_ready",  sel ? s_in_ready  : in_ready,  1);
        @(posedge clock); #1;
    endtask

    task automatic wait_done(input bit sel);
        bit d = 1'b0;
        for (int t = 0; t < 300 && !d; t++) begin
            @(negedge clock);
            d = sel ? s_done : done;
        end
        check("done_seen", d, 1);
        check("done_cpu_reset", sel ? s_cpu_reset : cpu_reset, 0);
        @(posedge clock); #1;
    endtask

    task automatic offer_idle(input bit sel);
        set_in(sel, 1'b1, 8'h5A);
        repeat (3) begin
            @(negedge clock);
            check("idle_in_ready", sel ? s_in_ready : in_ready, 0);
        end
        @(posedge clock); #1;
        set_in(sel, 1'b0, 8'h00);
    endtask

    task automatic check_reset_values();
        check("rv_in_ready",  in_ready,           0);
        check("rv_wr_en",     mem_wr_en,          0);
        check("rv_addr",      32'(mem_addr),      0);
        check("rv_data",      mem_data,           0);
        check("rv_cpu_reset", cpu_reset,          1);
        check("rv_done",      done,               0);
        check("rv_error",     error,              0);
        check("rv_s_ready",   s_in_ready,         0);
        check("rv_s_cpu_rst", s_cpu_reset,        1);
    endtask

    function automatic vec_t mk(input logic [15:0] n, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3, input bit gaps);
        vec_t v;
        v.n = n;
        v.w = '0;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.gaps = gaps;
        v.exp_writes = int'(n);
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t             tbl[4];
        logic [3:0][31:0] w;
        int               base;
        wr_t              e;

        tbl[0] = mk(16'd2, 32'h20080005, 32'h0000000C, 32'h0, 32'h0, 1'b1);
        tbl[1] = mk(16'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        tbl[2] = mk(16'd3, 32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C, 32'h0, 1'b0);
        tbl[3] = mk(16'd1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 1'b1);

        reset = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; restart = 1'b0;
        s_in_valid = 1'b0; s_in_data = 8'h00; s_restart = 1'b0;

        #12;
        check_reset_values();
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;

        // Continuous two-word program: latency, throughput and done timing.
        w = '0; w[0] = 32'h20080005; w[1] = 32'h0000000C;
        send_prog(1'b0, 16'd2, w, 1'b0);
        @(negedge clock);
        check("a_wr_latency", mem_wr_en, 1);
        check("a_done_early", done, 0);
        check("a_ready_write", in_ready, 0);
        @(negedge clock);
        check("a_done", done, 1);
        check("a_cpu_reset", cpu_reset, 0);
        check("a_wr_off", mem_wr_en, 0);
        check("a_wr_gap", 32'(wr_gap), 5);
        check("a_wr_count", 32'(wr_count), 2);
        @(posedge clock); #1;
        offer_idle(1'b0);

        foreach (tbl[i]) begin
            base = wr_count;
            pulse_restart(1'b0);
            send_prog(1'b0, tbl[i].n, tbl[i].w, tbl[i].gaps);
            @(negedge clock);
            if (tbl[i].n == 16'd0) check("t_n0_done_latency", done, 1);
            else                   check("t_wr_latency", mem_wr_en, 1);
            wait_done(1'b0);
            check("t_wr_count", 32'(wr_count - base), 32'(tbl[i].exp_writes));
            offer_idle(1'b0);
            check("t_done_hold", done, 1);
        end

        // Reset in the middle of word 0 discards the partial word.
        pulse_restart(1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        send_byte(1'b0, 8'h02, 1'b0);
        send_byte(1'b0, 8'h20, 1'b0);
        send_byte(1'b0, 8'h08, 1'b0);
        #2 reset = 1'b0;
        #1 check_reset_values();
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        base = wr_count;
        w = '0; w[0] = 32'hAABBCCDD;
        send_prog(1'b0, 16'd1, w, 1'b0);
        wait_done(1'b0);
        check("mr_wr_count", 32'(wr_count - base), 1);

        // Restart from DONE, with a restart pulse in DATA that must be ignored.
        base = wr_count;
        pulse_restart(1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        send_byte(1'b0, 8'h01, 1'b0);
        send_byte(1'b0, 8'h11, 1'b0);
        send_byte(1'b0, 8'h22, 1'b0);
        restart = 1'b1;
        @(posedge clock); #1;
        restart = 1'b0;
        @(negedge clock);
        check("rs_ignored_ready", in_ready, 1);
        check("rs_ignored_cpu_reset", cpu_reset, 1);
        @(posedge clock); #1;
        send_byte(1'b0, 8'h33, 1'b0);
        send_byte(1'b0, 8'h44, 1'b0);
        e.addr = 16'd0; e.data = 32'h11223344;
        exp_q.push_back(e);
        wait_done(1'b0);
        check("rs_wr_count", 32'(wr_count - base), 1);

        // Small memory: oversize header errors out, N==DEPTH fills every address.
        send_byte(1'b1, 8'h00, 1'b0);
        send_byte(1'b1, 8'h05, 1'b0);
        @(negedge clock);
        check("e_error", s_error, 1);
        check("e_cpu_reset", s_cpu_reset, 1);
        check("e_in_ready", s_in_ready, 0);
        check("e_done", s_done, 0);
        @(posedge clock); #1;
        offer_idle(1'b1);
        check("e_error_hold", s_error, 1);
        check("e_no_writes", 32'(s_wr_count), 0);
        pulse_restart(1'b1);
        w = '0;
        w[0] = 32'hC0DE0000; w[1] = 32'hC0DE0001; w[2] = 32'hC0DE0002; w[3] = 32'hC0DE0003;
        send_prog(1'b1, 16'd4, w, 1'b1);
        wait_done(1'b1);
        check("full_wr_count", 32'(s_wr_count), 4);

        check("sb_empty", 32'(exp_q.size()), 0);
        check("s_sb_empty", 32'(s_exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Program loader that fills the instruction memory read by the arithmetic machine. It accepts a byte stream over a valid/ready handshake, packs the bytes big-endian into 32-bit instruction words and writes them to consecutive word addresses starting at 0. While loading it holds the machine in reset, so the machine only fetches once the program is complete.

## Interface
Parameters:
- ADDR_W, 10: instruction-memory word-address width. Capacity DEPTH = 2^ADDR_W words.

Ports:
- clock  input  1  the single clock, rising-edge.
- reset  input  1  asynchronous, active-low. 0 = in reset.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- restart  input  1  one-cycle pulse that starts a reload. Honoured only in DONE or ERR.
- mem_wr_en  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  word address, matching PC[31:2] indexing.
- mem_data  output  32  instruction word.
- cpu_reset  output  1  active-high reset to the arithmetic machine.
- done  output  1  program loaded.
- error  output  1  header count exceeds DEPTH.

## Operation
- Stream format:
  - 2-byte header: word count N, MSB first.
  - Then 4N bytes, each word MSB first (the first byte goes to bits 31:24).
- A byte is consumed on a rising edge where in_valid && in_ready. Bytes offered while in_ready=0 are not consumed; the sender holds them.
- States and transitions:
  - HDR_HI: consume a byte into count[15:8], then go to HDR_LO.
  - HDR_LO: consume a byte into count[7:0], then:
    - N==0: go to DONE.
    - N>DEPTH: go to ERR.
    - otherwise: clear word index and byte index, go to DATA.
  - DATA: consume a byte and shift it into the word register. On the 4th byte (byte index 3), go to WRITE.
  - WRITE (exactly 1 cycle): mem_wr_en=1, mem_addr=word index, mem_data=assembled word.
    - Word index == N-1: go to DONE.
    - Otherwise: increment word index, clear byte index, go to DATA.
  - DONE: done=1, cpu_reset=0. restart → HDR_HI.
  - ERR: error=1, cpu_reset=1. restart → HDR_HI.
- Entering HDR_HI via restart clears count, indices, done and error, and sets cpu_reset=1 in the same edge.
- in_ready:
  - 1 in HDR_HI, HDR_LO and DATA; 0 in WRITE, DONE and ERR.
  - Forced to 0 whenever reset=0.
- Width rules:
  - count is 16 bits; the comparison against DEPTH is done in 17 bits.
  - N==DEPTH is legal and writes addresses 0..DEPTH-1.
  - The word index never wraps.
- restart outside DONE/ERR is ignored. in_valid in DONE/ERR is ignored, and those bytes are not consumed.

## Timing
- Reset values (applied asynchronously on reset=0):
  - State HDR_HI.
  - in_ready=0, mem_wr_en=0, mem_addr=0, mem_data=0.
  - cpu_reset=1, done=0, error=0.
  - All counters 0.
- Reset mid-operation aborts the load. Partially assembled words are discarded and no further write occurs.
- mem_wr_en, mem_addr, mem_data, cpu_reset, done and error are registered outputs.
- Write latency: mem_wr_en rises in the cycle after the edge that consumed a word's 4th byte.
- Throughput: 5 cycles per word with continuous in_valid (4 accept cycles plus 1 WRITE).
- done/cpu_reset latency:
  - done rises and cpu_reset falls on the edge after the last WRITE cycle.
  - For N==0, this happens on the edge after the HDR_LO accept.
- error rises on the edge after the HDR_LO accept.

## Structure
- Shared package holds:
  - the state enum (HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR);
  - HDR_BYTES=2 and BYTES_PER_WORD=4.
- One natural sub-module, word_assembler:
  - 32-bit shift register plus 2-bit byte counter;
  - inputs: shift enable, clear;
  - outputs: word and a last-byte flag.
- The FSM, header counter and word index live in inst_loader.

## Test plan
- Reset, then continuous stream 00 02 20 08 00 05 00 00 00 0C → two one-cycle writes, in order:
  - mem_addr=0, mem_data=0x20080005;
  - mem_addr=1, mem_data=0x0000000C.
  - Then done=1 and cpu_reset=0 on the next edge. in_ready=0 during each WRITE cycle.
- Stream 00 00 → no mem_wr_en; done=1 one edge after the 2nd byte; further bytes are not consumed.
- ADDR_W=2, stream 00 05 → error=1, cpu_reset=1, in_ready=0, no writes. A restart pulse returns to HDR_HI with error=0.
- Same program as the first test with in_valid toggling randomly → identical writes and addresses; in_data is only consumed when in_ready=1.
- reset=0 after 2 data bytes of word 1 → all outputs take their reset values immediately. After release, a new stream 00 01 AA BB CC DD → a single write, addr 0, data 0xAABBCCDD.
- In DONE, pulse restart and send 00 01 11 22 33 44 → cpu_reset=1 on the restart edge; write addr 0 = 0x11223344; done again. A restart pulse during DATA is ignored.
